// File: rtl/nibble_serial_adder32_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer and ALU control.
package nibble_serial_adder32_pkg;

    localparam int unsigned NIB_W = 4;

    // ALU op select as seen on the sub input; OP_SUB is shared with ALU control.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder32_if.sv
// Request/response bundle between ALU control (master) and the serial adder (slave).
interface nibble_serial_adder32_if #(
    parameter int WIDTH = 32
);

    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             ovf;
    logic             zero;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, c_out, ovf, zero
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, c_out, ovf, zero
    );

endinterface

// File: rtl/cla_adder4bit.sv
// 4-bit carry-lookahead adder cell.
module cla_adder4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // Generate/propagate lookahead carries, all flattened from c_in.
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = c_in;
        c[1] = g[0] | (p[0] & c_in);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c_in);
        sum   = p ^ c[3:0];
        c_out = c[4];
    end

endmodule

// File: rtl/nibble_serial_adder32.sv
// Multi-cycle add/subtract: one nibble per clock through a single CLA cell, LSB nibble first.
module nibble_serial_adder32
    import nibble_serial_adder32_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    nibble_serial_adder32_if.slave  bus
);

    localparam int NIBS = WIDTH / NIB_W;
    localparam int CW   = $clog2(NIBS);
    localparam logic [CW-1:0] LAST_NIB = CW'(NIBS - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] result_reg;
    logic             c_out_reg;
    logic             ovf_reg;
    logic             zero_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [CW+1:0]    base;
    logic [3:0]       cell_a;
    logic [3:0]       cell_b;
    logic [3:0]       cell_sum;
    logic             cell_co;
    logic [WIDTH-1:0] result_upd;

    // Counter-driven nibble select; operand registers never shift.
    always_comb begin
        base       = {cnt, 2'b00};
        cell_a     = a_reg[base +: NIB_W];
        cell_b     = b_reg[base +: NIB_W];
        result_upd = result_reg;
        result_upd[base +: NIB_W] = cell_sum;
    end

    cla_adder4bit u_cla (
        .a     (cell_a),
        .b     (cell_b),
        .c_in  (carry),
        .sum   (cell_sum),
        .c_out (cell_co)
    );

    // Sequencer FSM with registered handshake, result and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            carry      <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
            c_out_reg  <= 1'b0;
            ovf_reg    <= 1'b0;
            zero_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    done_reg <= 1'b0;
                    busy_reg <= 1'b0;
                    if (bus.start) begin
                        // Subtract as A + ~B + 1: invert B and seed the carry with sub.
                        a_reg      <= bus.a;
                        b_reg      <= (bus.sub == OP_SUB) ? ~bus.b : bus.b;
                        carry      <= bus.sub;
                        cnt        <= '0;
                        result_reg <= '0;
                        busy_reg   <= 1'b1;
                        state      <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    result_reg <= result_upd;
                    carry      <= cell_co;
                    if (cnt == LAST_NIB) begin
                        cnt       <= '0;
                        c_out_reg <= cell_co;
                        ovf_reg   <= (a_reg[WIDTH-1] == b_reg[WIDTH-1])
                                     && (cell_sum[3] != a_reg[WIDTH-1]);
                        zero_reg  <= (result_upd == '0);
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_reg;
    assign bus.done   = done_reg;
    assign bus.result = result_reg;
    assign bus.c_out  = c_out_reg;
    assign bus.ovf    = ovf_reg;
    assign bus.zero   = zero_reg;

endmodule

// File: tb/tb_nibble_serial_adder32.sv
// Scoreboard bench: stimulus pushes expected responses, a monitor pops them on done.
module tb_nibble_serial_adder32;

    localparam int WIDTH = 32;
    localparam int NIBS  = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    nibble_serial_adder32_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_adder32 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] res;
        logic        c;
        logic        o;
        logic        z;
        int unsigned acc;
    } exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] res;
        logic        c;
        logic        o;
        logic        z;
    } vec_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(bus.done), 64'(0));
            end else begin
                e = sb.pop_front();
                check("result", 64'(bus.result), 64'(e.res));
                check("flags_c_ovf_zero", 64'({bus.c_out, bus.ovf, bus.zero}),
                      64'({e.c, e.o, e.z}));
                check("latency", 64'(cyc - e.acc), 64'(NIBS));
                check("busy_low_in_done", 64'(bus.busy), 64'(0));
            end
        end
    end

    // Drive a request now, let the next edge accept it, then record the expectation.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic [31:0] res, input logic c, input logic o, input logic z);
        exp_t e;
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.sub   = sub;
        @(posedge clk);
        #1;
        e.res = res;
        e.c   = c;
        e.o   = o;
        e.z   = z;
        e.acc = cyc;
        sb.push_back(e);
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.sub   = 1'($urandom);
        check("busy_after_accept", 64'(bus.busy), 64'(1));
    endtask

    task automatic idle_window();
        repeat (NIBS + 3) @(posedge clk);
        #1;
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{32'h1234_ABCD, 32'h0000_0000, 1'b1, 32'h1234_ABCD, 1'b1, 1'b0, 1'b0};

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.sub   = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs",
              64'({bus.busy, bus.done, bus.result, bus.c_out, bus.ovf, bus.zero}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed arithmetic vectors.
        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].res, vecs[i].c, vecs[i].o,
                  vecs[i].z);
            idle_window();
        end

        // start during RUN cycle 3 is ignored.
        issue(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a     = 32'hDEAD_BEEF;
        bus.b     = 32'h0000_0001;
        bus.sub   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("busy_through_ignored_start", 64'(bus.busy), 64'(1));
        idle_window();

        // start during DONE: accepted with no IDLE gap.
        issue(32'h1000_0000, 32'h2000_0000, 1'b0, 32'h3000_0000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20 && !bus.done; i++) @(negedge clk);
        check("b2b_first_done_seen", 64'(bus.done), 64'(1));
        issue(32'hA000_0000, 32'hA000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        check("b2b_done_cleared", 64'(bus.done), 64'(0));
        idle_window();

        // Reset during RUN cycle 4 discards the op.
        issue(32'hDEAD_BEEF, 32'h0101_0101, 1'b0, 32'hDFAE_BFF0, 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              64'({bus.busy, bus.done, bus.result, bus.c_out, bus.ovf, bus.zero}), 64'(0));
        void'(sb.pop_back());
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);
        idle_window();

        // Every outstanding expectation must have been matched by a done pulse.
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(posedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
